// File: rtl/cchw_pkg.sv
// Shared definitions for the sample feeder path into OperationManager and the octave stores.
package cchw_pkg;

  localparam int SAMPLE_W   = 20;
  localparam int NUM_OCT    = 5;
  localparam int FIFO_DEPTH = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Circular sample buffer with an occupancy counter; a pop frees a slot for a push in the same cycle.
module sample_fifo
  import cchw_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [N-1:0]             din,
  input  logic                     pop,
  output logic [N-1:0]             head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sample_feeder.sv
// Buffers audio samples for OperationManager and presents per-octave pairwise-averaged samples
// to the octave stores on the same cycle as each writeSample pop.
module sample_feeder
  import cchw_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int OCT   = NUM_OCT,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               inSample,
  input  logic                       inValid,
  output logic                       sampleReady,
  input  logic                       writeSample,
  output logic [OCT-1:0][N-1:0]      octSamples,
  output logic [OCT-1:0]             octWrite,
  output logic [$clog2(DEPTH):0]     fifoLevel,
  output logic                       overflow,
  input  logic                       clearOverflow
);

  logic [N-1:0]          head;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic [OCT-1:0]        cnt;
  logic [N-1:0]          held [OCT-1];
  logic [OCT-1:0][N-1:0] chain;
  logic [OCT-1:0]        wr;

  assign pop         = writeSample & ~empty;
  assign sampleReady = ~empty;

  sample_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inValid),
    .din   (inSample),
    .pop   (writeSample),
    .head  (head),
    .empty (empty),
    .full  (full),
    .level (fifoLevel)
  );

  assign chain[0] = head;
  assign wr[0]    = pop;

  // Octave k averages the stored first half of its pair with the octave k-1 sample arriving now;
  // the N+1 bit sum shifted right floors toward -inf.
  for (genvar k = 1; k < OCT; k++) begin : g_oct
    logic [N:0] sum;
    assign sum      = {held[k-1][N-1], held[k-1]} + {chain[k-1][N-1], chain[k-1]};
    assign chain[k] = N'(sum >> 1);
    assign wr[k]    = wr[k-1] & cnt[k-1];
  end

  assign octSamples = rst ? chain : '0;
  assign octWrite   = rst ? wr    : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < OCT-1; k++) held[k] <= '0;
    end else begin
      if (pop) cnt <= cnt + 1'b1;
      for (int k = 0; k < OCT-1; k++) begin
        if (wr[k] && !cnt[k]) held[k] <= chain[k];
      end
      // A fresh drop outranks a clear in the same cycle.
      if (inValid && full && !pop) overflow <= 1'b1;
      else if (clearOverflow)      overflow <= 1'b0;
    end
  end

endmodule
